// File: rtl/uart_rx_ctrl_pkg.sv
// Shared constants and FSM encoding for the UART receive controller.
package uart_rx_ctrl_pkg;

  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned CLKS_PER_BIT = 1085;  // 115200 baud at 125 MHz

  typedef enum logic [1:0] {
    StOff      = 2'd0,
    StActive   = 2'd1,
    StStopping = 2'd2
  } state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side and consumer-side signals of uart_rx_ctrl.
// slave is the controller's view; master is the surrounding logic's view.
interface uart_rx_ctrl_if
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic                  i_btn;
  logic                  i_rx_d;
  logic [DATA_WIDTH-1:0] i_rx_byte;
  logic                  o_rx_en;
  logic                  o_active;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [LW-1:0]         o_level;
  logic                  o_overrun;

  modport master (
    output i_btn, i_rx_d, i_rx_byte, i_ready,
    input  o_rx_en, o_active, o_data, o_valid, o_level, o_overrun
  );

  modport slave (
    input  i_btn, i_rx_d, i_rx_byte, i_ready,
    output o_rx_en, o_active, o_data, o_valid, o_level, o_overrun
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter; emits a one-cycle press pulse
// when the debounced level rises.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CLKS = 1_250_000
) (
  input  logic sysclk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CLKS) + 1;
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CLKS - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    // Any bounce back to the accepted level restarts the count.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-mode sequencer with guarded stop window and byte FIFO.
// Define RX_CTRL_TIMEOUT_EN to auto-stop after TIMEOUT_CLKS idle cycles in ACTIVE.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned DEBOUNCE_CLKS = 1_250_000,
  parameter int unsigned GUARD_CLKS    = CLKS_PER_BIT * 10,
  parameter int unsigned TIMEOUT_CLKS  = 125_000_000
) (
  input logic          sysclk,
  input logic          rst,
  uart_rx_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned GW = $clog2(GUARD_CLKS) + 1;
  localparam logic [GW-1:0] GuardLast = GW'(GUARD_CLKS - 1);

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || GUARD_CLKS < 1 ||
      DEBOUNCE_CLKS < 1 || TIMEOUT_CLKS < 2) begin : g_param_check
    $error("uart_rx_ctrl: illegal parameter value");
  end

  state_e                state_q, state_d;
  logic [GW-1:0]         guard_q, guard_d;
  logic                  press, stop_req;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_q, rd_q;
  logic                  overrun_q, overrun_d;
  logic                  empty, full, push_req, push, pop;

  btn_debounce #(
    .DEBOUNCE_CLKS(DEBOUNCE_CLKS)
  ) u_btn (
    .sysclk(sysclk),
    .rst   (rst),
    .btn   (bus.i_btn),
    .press (press)
  );

`ifdef RX_CTRL_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [IW-1:0] IdleLast = IW'(TIMEOUT_CLKS - 1);

  logic [IW-1:0] idle_q, idle_d;
  logic          timeout;

  // Counter is zero on entry to ACTIVE because it is held clear everywhere else.
  always_comb begin
    idle_d = '0;
    if (state_q == StActive && !bus.i_rx_d && !press) idle_d = idle_q + 1'b1;
  end

  assign timeout  = (state_q == StActive) && (idle_q == IdleLast) && !bus.i_rx_d;
  assign stop_req = press | timeout;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  assign stop_req = press;
`endif

  always_comb begin
    state_d = state_q;
    guard_d = '0;
    unique case (state_q)
      StOff:      if (press) state_d = StActive;
      StActive:   if (stop_req) state_d = StStopping;
      StStopping: begin
        if (press)                     state_d = StActive;
        else if (guard_q == GuardLast) state_d = StOff;
        else                           guard_d = guard_q + 1'b1;
      end
      default:    state_d = StOff;
    endcase
  end

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_req = bus.i_rx_d && (state_q != StOff);
  assign pop      = !empty && bus.i_ready;
  assign push     = push_req && (!full || pop);

  always_comb begin
    overrun_d = overrun_q;
    if (state_q == StOff && press)   overrun_d = 1'b0;
    else if (push_req && full && !pop) overrun_d = 1'b1;
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q   <= StOff;
      guard_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      overrun_q <= overrun_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= bus.i_rx_byte;
  end

  assign bus.o_rx_en   = (state_q != StOff);
  assign bus.o_active  = (state_q == StActive);
  assign bus.o_valid   = !empty;
  assign bus.o_data    = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign bus.o_level   = wr_q - rd_q;
  assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus a randomized
// push/pop run scored against a queue model of the FIFO.
module tb_uart_rx_ctrl;
  import uart_rx_ctrl_pkg::*;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned DEB     = 200;
  localparam int unsigned GUARD   = 300;
  localparam int unsigned TIMEOUT = 1000;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;

  uart_rx_ctrl_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_ctrl #(
    .DEPTH        (DEPTH),
    .DEBOUNCE_CLKS(DEB),
    .GUARD_CLKS   (GUARD),
    .TIMEOUT_CLKS (TIMEOUT)
  ) dut (
    .sysclk(sysclk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 sysclk = ~sysclk;

  int unsigned           n_cmp  = 0;
  int unsigned           n_fail = 0;
  logic [DATA_WIDTH-1:0] mq[$];
  bit                    m_en   = 1'b0;
  bit                    m_ovr  = 1'b0;

  // One clock of stimulus; the model applies the same transaction rules.
  task automatic tick(input bit d, input logic [DATA_WIDTH-1:0] b, input bit rdy);
    bit do_pop, do_push;
    do_pop  = rdy && (mq.size() > 0);
    do_push = d && m_en;
    bus.i_rx_d = d; bus.i_rx_byte = b; bus.i_ready = rdy;
    @(posedge sysclk); #1;
    bus.i_rx_d = 1'b0; bus.i_ready = 1'b0;
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      if (mq.size() < DEPTH) mq.push_back(b);
      else                   m_ovr = 1'b1;
    end
  endtask

  // Holds the button until o_active toggles; lat is edges from press to toggle, -1 on timeout.
  task automatic do_press(output int lat);
    logic start;
    repeat (DEB + 5) tick(1'b0, '0, 1'b0);
    start = bus.o_active;
    bus.i_btn = 1'b1;
    lat = -1;
    for (int i = 1; i <= int'(DEB) + 20; i++) begin
      tick(1'b0, '0, 1'b0);
      if (bus.o_active !== start) begin lat = i; break; end
    end
    bus.i_btn = 1'b0;
  endtask

  task automatic test_reset;
    bus.i_btn = 1'b0; bus.i_rx_d = 1'b0; bus.i_rx_byte = '0; bus.i_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    n_cmp++; if (bus.o_rx_en !== 1'b0) begin n_fail++; $display("FAIL reset_rx_en got %b want 0", bus.o_rx_en); end
    n_cmp++; if (bus.o_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", bus.o_active); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", bus.o_level); end
    n_cmp++; if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", bus.o_overrun); end
    n_cmp++; if (bus.o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", bus.o_data); end
    rst = 1'b0;
    tick(1'b0, '0, 1'b0);
  endtask

  task automatic test_button;
    int lat;
    bit seen;
    bus.i_btn = 1'b1;
    repeat (100) tick(1'b0, '0, 1'b0);
    bus.i_btn = 1'b0;
    seen = 1'b0;
    repeat (DEB + 20) begin
      tick(1'b0, '0, 1'b0);
      if (bus.o_rx_en !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL glitch_press rx_en rose want stay 0"); end
    do_press(lat);
    n_cmp++; if (lat != int'(DEB) + 3) begin n_fail++; $display("FAIL press_latency got %0d want %0d", lat, DEB + 3); end
    n_cmp++; if (bus.o_rx_en !== 1'b1) begin n_fail++; $display("FAIL press_rx_en got %b want 1", bus.o_rx_en); end
    m_en = 1'b1; m_ovr = 1'b0;
    repeat (DEB + 10) tick(1'b0, '0, 1'b0);
    n_cmp++; if (bus.o_active !== 1'b1) begin n_fail++; $display("FAIL release_active got %b want 1", bus.o_active); end
  endtask

  task automatic test_fifo_basic;
    tick(1'b1, 8'h41, 1'b0);
    tick(1'b1, 8'h42, 1'b0);
    n_cmp++; if (bus.o_level !== 4'd2) begin n_fail++; $display("FAIL basic_level got %0d want 2", bus.o_level); end
    n_cmp++; if (bus.o_data !== 8'h41) begin n_fail++; $display("FAIL basic_head got %h want 41", bus.o_data); end
    tick(1'b0, '0, 1'b1);
    n_cmp++; if (bus.o_data !== 8'h42) begin n_fail++; $display("FAIL basic_pop1 got %h want 42", bus.o_data); end
    tick(1'b0, '0, 1'b1);
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop2_valid got %b want 0", bus.o_valid); end
  endtask

  task automatic test_full_pushpop;
    logic [DATA_WIDTH-1:0] last;
    for (int i = 0; i < int'(DEPTH); i++) tick(1'b1, 8'(i), 1'b0);
    tick(1'b1, 8'h55, 1'b1);
    n_cmp++; if (bus.o_level !== 4'd8) begin n_fail++; $display("FAIL fullpp_level got %0d want 8", bus.o_level); end
    n_cmp++; if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL fullpp_overrun got %b want 0", bus.o_overrun); end
    last = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      n_cmp++; if (bus.o_data !== mq[0]) begin n_fail++; $display("FAIL fullpp_order got %h want %h", bus.o_data, mq[0]); end
      last = bus.o_data;
      tick(1'b0, '0, 1'b1);
    end
    n_cmp++; if (last !== 8'h55) begin n_fail++; $display("FAIL fullpp_last got %h want 55", last); end
  endtask

  task automatic test_overrun;
    for (int i = 0; i <= int'(DEPTH); i++) tick(1'b1, 8'(i), 1'b0);
    n_cmp++; if (bus.o_level !== 4'd8) begin n_fail++; $display("FAIL ovr_level got %0d want 8", bus.o_level); end
    n_cmp++; if (bus.o_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", bus.o_overrun); end
    n_cmp++; if (bus.o_data !== 8'h00) begin n_fail++; $display("FAIL ovr_head got %h want 00", bus.o_data); end
  endtask

  task automatic test_random;
    int unsigned errs = 0;
    for (int c = 0; c < 400; c++) begin
      tick($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < (c < 200 ? 40 : 70));
      n_cmp++;
      if (bus.o_level !== 4'(mq.size()) || bus.o_valid !== (mq.size() > 0) ||
          bus.o_overrun !== m_ovr || (mq.size() > 0 && bus.o_data !== mq[0])) begin
        n_fail++;
        if (errs++ < 5)
          $display("FAIL random c=%0d got lvl=%0d v=%b ovr=%b d=%h want lvl=%0d ovr=%b d=%h", c,
                   bus.o_level, bus.o_valid, bus.o_overrun, bus.o_data, mq.size(), m_ovr,
                   (mq.size() > 0) ? mq[0] : 8'h00);
      end
    end
  endtask

  task automatic test_guard;
    int lat;
    for (int i = 0; i < 20 && mq.size() > 0; i++) tick(1'b0, '0, 1'b1);
    do_press(lat);
    n_cmp++; if (lat != int'(DEB) + 3) begin n_fail++; $display("FAIL stop_latency got %0d want %0d", lat, DEB + 3); end
    n_cmp++; if (bus.o_rx_en !== 1'b1) begin n_fail++; $display("FAIL stop_rx_en got %b want 1", bus.o_rx_en); end
    repeat (GUARD - 2) tick(1'b0, '0, 1'b0);
    tick(1'b1, 8'h7E, 1'b0);
    n_cmp++; if (bus.o_rx_en !== 1'b1) begin n_fail++; $display("FAIL guard_end_rx_en got %b want 1", bus.o_rx_en); end
    n_cmp++; if (bus.o_level !== 4'd1 || bus.o_data !== 8'h7E) begin
      n_fail++; $display("FAIL guard_capture got lvl=%0d d=%h want lvl=1 d=7e", bus.o_level, bus.o_data);
    end
    tick(1'b0, '0, 1'b0);
    m_en = 1'b0;
    n_cmp++; if (bus.o_rx_en !== 1'b0) begin n_fail++; $display("FAIL guard_off_rx_en got %b want 0", bus.o_rx_en); end
    tick(1'b1, 8'hAA, 1'b0);
    n_cmp++; if (bus.o_level !== 4'd1) begin n_fail++; $display("FAIL off_ignore_level got %0d want 1", bus.o_level); end
    do_press(lat);
    m_en = 1'b1; m_ovr = 1'b0;
    n_cmp++; if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL restart_overrun got %b want 0", bus.o_overrun); end
    n_cmp++; if (bus.o_data !== 8'h7E) begin n_fail++; $display("FAIL restart_kept got %h want 7e", bus.o_data); end
  endtask

  task automatic test_reset_mid_guard;
    int lat;
    tick(1'b1, 8'h11, 1'b0);
    tick(1'b1, 8'h22, 1'b0);
    do_press(lat);
    repeat (50) tick(1'b0, '0, 1'b0);
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (bus.o_rx_en !== 1'b0) begin n_fail++; $display("FAIL midrst_rx_en got %b want 0", bus.o_rx_en); end
    n_cmp++; if (bus.o_level !== 4'd0 || bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_fifo got lvl=%0d v=%b want 0 0", bus.o_level, bus.o_valid);
    end
    mq.delete(); m_en = 1'b0; m_ovr = 1'b0;
    repeat (3) @(posedge sysclk);
    #1 rst = 1'b0;
    tick(1'b0, '0, 1'b0);
  endtask

`ifdef RX_CTRL_TIMEOUT_EN
  task automatic test_timeout;
    int lat;
    do_press(lat);
    m_en = 1'b1; m_ovr = 1'b0;
    repeat (TIMEOUT - 1) tick(1'b0, '0, 1'b0);
    tick(1'b1, 8'hC3, 1'b0);
    n_cmp++; if (bus.o_active !== 1'b1) begin n_fail++; $display("FAIL tmo_byte_keeps got %b want 1", bus.o_active); end
    repeat (TIMEOUT - 1) tick(1'b0, '0, 1'b0);
    n_cmp++; if (bus.o_active !== 1'b1) begin n_fail++; $display("FAIL tmo_early got %b want 1", bus.o_active); end
    tick(1'b0, '0, 1'b0);
    n_cmp++; if (bus.o_active !== 1'b0 || bus.o_rx_en !== 1'b1) begin
      n_fail++; $display("FAIL tmo_stop got act=%b en=%b want 0 1", bus.o_active, bus.o_rx_en);
    end
    repeat (GUARD) tick(1'b0, '0, 1'b0);
    m_en = 1'b0;
    n_cmp++; if (bus.o_rx_en !== 1'b0) begin n_fail++; $display("FAIL tmo_off got %b want 0", bus.o_rx_en); end
  endtask
`endif

  initial begin
    test_reset();
    test_button();
    test_fifo_basic();
    test_full_pushpop();
    test_overrun();
    test_random();
    test_guard();
    test_reset_mid_guard();
`ifdef RX_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
